// File: rtl/key_progress_pkg.sv
// Shared game definitions for the stage-1 key tracker: game state codes,
// key box geometry, renderer object codes and the tracker FSM encoding.
package key_progress_pkg;

  typedef enum logic [3:0] {
    ST_TITLE    = 4'd0,
    ST_STAGE1   = 4'd2,
    ST_SUCCESS1 = 4'd3,
    ST_FAIL     = 4'd8
  } game_state_e;

  typedef enum logic [1:0] {
    OBJ_NONE       = 2'd0,
    OBJ_FIND_KEY   = 2'd1,
    OBJ_FIND_LIGHT = 2'd2,
    OBJ_FIND_DOOR  = 2'd3
  } obj_find_e;

  typedef enum logic [2:0] {
    KP_IDLE  = 3'd0,
    KP_HUNT  = 3'd1,
    KP_COOL  = 3'd2,
    KP_ALL   = 3'd3,
    KP_CLEAR = 3'd4
  } kp_state_e;

  localparam int KEY_SIZE = 20;

  // Top-left corners of the three key sprites, half-res coordinates.
  localparam int K0_X = 65;
  localparam int K0_Y = 35;
  localparam int K1_X = 235;
  localparam int K1_Y = 35;
  localparam int K2_X = 235;
  localparam int K2_Y = 205;

  // Half-open rectangle overlap; ends are exclusive, all values 10 bits wide
  // so a player near the right/bottom edge cannot wrap around.
  function automatic logic box_overlap(
    input logic [9:0] ax0, input logic [9:0] ax1,
    input logic [9:0] ay0, input logic [9:0] ay1,
    input logic [9:0] bx0, input logic [9:0] bx1,
    input logic [9:0] by0, input logic [9:0] by1
  );
    return (ax0 < bx1) && (ax1 > bx0) && (ay0 < by1) && (ay1 > by0);
  endfunction

endpackage

// File: rtl/key_progress_btn_onepulse.sv
// Button conditioner: two-flop synchroniser followed by a rising-edge
// detector. o_pulse is high for one cycle, combinationally from flops, so
// the consumer registers it on the third edge after the raw rise.
module btn_onepulse (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronise the raw button and keep the previous synchronised level.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/key_progress.sv
// Stage-1 key collection tracker. Counts picks on the currently visible key,
// enforces a cooldown between picks and requests the door unlock once all
// three keys are held and the player picks at the door.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   KP_IDLE  | not in stage 1, key_find held at 0
//   KP_HUNT  | waiting for a pick that overlaps the visible key
//   KP_COOL  | cooldown after a pick, picks ignored
//   KP_ALL   | all keys held, waiting for a pick inside the door region
//   KP_CLEAR | door requested, holding key_find=3 with no pulses
module key_progress
  import key_progress_pkg::*;
#(
  parameter int PLAYER_W = 16,
  parameter int PLAYER_H = 16,
  parameter int DOOR_X0  = 150,
  parameter int DOOR_X1  = 170,
  parameter int DOOR_Y0  = 200,
  parameter int DOOR_Y1  = 240,
  parameter int COOLDOWN = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_state,
  input  logic [8:0] i_player_x,
  input  logic [8:0] i_player_y,
  input  logic       i_btn_pick,
  output logic [1:0] o_key_find,
  output logic       o_key_pulse,
  output logic       o_door_open
);

  localparam int CNT_W = (COOLDOWN > 2) ? $clog2(COOLDOWN) : 1;

  kp_state_e        r_state;
  logic [1:0]       r_key_find;
  logic             r_key_pulse;
  logic             r_door_open;
  logic [CNT_W-1:0] r_cool_cnt;

  logic       w_pick_evt;
  logic [9:0] w_px0, w_px1, w_py0, w_py1;
  logic [9:0] w_kx0, w_ky0;
  logic       w_key_valid;
  logic       w_key_hit;
  logic       w_door_hit;
  logic       w_in_stage;

  btn_onepulse u_btn_pick (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn_pick),
    .o_pulse (w_pick_evt)
  );

  assign w_px0 = {1'b0, i_player_x};
  assign w_py0 = {1'b0, i_player_y};
  assign w_px1 = w_px0 + 10'(PLAYER_W);
  assign w_py1 = w_py0 + 10'(PLAYER_H);

  // Select the box of the key currently drawn; none once all are held.
  always_comb begin
    w_kx0       = 10'd0;
    w_ky0       = 10'd0;
    w_key_valid = 1'b1;
    case (r_key_find)
      2'd0:    begin w_kx0 = 10'(K0_X); w_ky0 = 10'(K0_Y); end
      2'd1:    begin w_kx0 = 10'(K1_X); w_ky0 = 10'(K1_Y); end
      2'd2:    begin w_kx0 = 10'(K2_X); w_ky0 = 10'(K2_Y); end
      default: w_key_valid = 1'b0;
    endcase
  end

  assign w_key_hit = w_key_valid &&
                     box_overlap(w_px0, w_px1, w_py0, w_py1,
                                 w_kx0, w_kx0 + 10'(KEY_SIZE),
                                 w_ky0, w_ky0 + 10'(KEY_SIZE));

  assign w_door_hit = box_overlap(w_px0, w_px1, w_py0, w_py1,
                                  10'(DOOR_X0), 10'(DOOR_X1),
                                  10'(DOOR_Y0), 10'(DOOR_Y1));

  assign w_in_stage = (i_state == 4'(ST_STAGE1)) || (i_state == 4'(ST_SUCCESS1));

  // Tracker FSM with registered key index and one-cycle pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= KP_IDLE;
      r_key_find  <= 2'd0;
      r_key_pulse <= 1'b0;
      r_door_open <= 1'b0;
      r_cool_cnt  <= '0;
    end else begin
      r_key_pulse <= 1'b0;
      r_door_open <= 1'b0;
      if (r_state != KP_IDLE && !w_in_stage) begin
        // Leaving the stage wins over any pick in the same cycle.
        r_state    <= KP_IDLE;
        r_key_find <= 2'd0;
        r_cool_cnt <= '0;
      end else begin
        case (r_state)
          KP_IDLE: begin
            r_key_find <= 2'd0;
            if (i_state == 4'(ST_STAGE1)) r_state <= KP_HUNT;
          end
          KP_HUNT: begin
            if (w_pick_evt && w_key_hit) begin
              r_key_find  <= r_key_find + 2'd1;
              r_key_pulse <= 1'b1;
              if (r_key_find == 2'd2) begin
                r_state <= KP_ALL;
              end else begin
                r_cool_cnt <= CNT_W'(COOLDOWN - 1);
                r_state    <= KP_COOL;
              end
            end
          end
          KP_COOL: begin
            if (r_cool_cnt == '0) r_state <= KP_HUNT;
            else                  r_cool_cnt <= r_cool_cnt - 1'b1;
          end
          KP_ALL: begin
            if (w_pick_evt && w_door_hit) begin
              r_door_open <= 1'b1;
              r_state     <= KP_CLEAR;
            end
          end
          KP_CLEAR: begin
            r_key_find <= 2'd3;
          end
          default: begin
            r_state    <= KP_IDLE;
            r_key_find <= 2'd0;
          end
        endcase
      end
    end
  end

  assign o_key_find  = r_key_find;
  assign o_key_pulse = r_key_pulse;
  assign o_door_open = r_door_open;

endmodule

// File: tb/tb_key_progress.sv
// Bench for key_progress: directed walk through the stage plus a randomized
// run, every cycle compared against a behavioural model of the key rules.
module tb_key_progress;

  localparam int COOL = 8;

  logic       clk;
  logic       rst;
  logic [3:0] state;
  logic [8:0] player_x;
  logic [8:0] player_y;
  logic       btn_pick;
  logic [1:0] o_key_find;
  logic       o_key_pulse;
  logic       o_door_open;

  key_progress #(.COOLDOWN(COOL)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_state     (state),
    .i_player_x  (player_x),
    .i_player_y  (player_y),
    .i_btn_pick  (btn_pick),
    .o_key_find  (o_key_find),
    .o_key_pulse (o_key_pulse),
    .o_door_open (o_door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: progress through the stage in terms of keys held,
  // cooldown cycles remaining and whether the door was already requested.
  int kx0[3] = '{65, 235, 235};
  int ky0[3] = '{35, 35, 205};
  int m_keys = 0;
  int m_cool = 0;
  bit m_act  = 0;
  bit m_door = 0;
  bit mp = 0, md = 0;
  bit h1 = 0, h2 = 0, h3 = 0;

  function automatic bit ov(int px, int py, int x0, int x1, int y0, int y1);
    int lx, hx, ly, hy;
    lx = (px > x0) ? px : x0;
    hx = (px + 16 < x1) ? px + 16 : x1;
    ly = (py > y0) ? py : y0;
    hy = (py + 16 < y1) ? py + 16 : y1;
    return (lx < hx) && (ly < hy);
  endfunction

  task automatic model_edge();
    bit pick;
    int px, py, st;
    mp = 0;
    md = 0;
    if (rst) begin
      m_act = 0; m_keys = 0; m_cool = 0; m_door = 0;
      h1 = 0; h2 = 0; h3 = 0;
      return;
    end
    px = int'(player_x);
    py = int'(player_y);
    st = int'(state);
    // A button rise reaches the tracker on the third sampling edge.
    pick = h2 && !h3;
    h3 = h2; h2 = h1; h1 = btn_pick;
    if (!m_act) begin
      m_keys = 0;
      if (st == 2) m_act = 1;
    end else if (!(st == 2 || st == 3)) begin
      m_act = 0; m_keys = 0; m_cool = 0; m_door = 0;
    end else if (m_keys < 3) begin
      if (m_cool > 0) m_cool--;
      else if (pick && ov(px, py, kx0[m_keys], kx0[m_keys] + 20,
                          ky0[m_keys], ky0[m_keys] + 20)) begin
        m_keys++;
        mp = 1;
        if (m_keys < 3) m_cool = COOL;
      end
    end else if (!m_door) begin
      if (pick && ov(px, py, 150, 170, 200, 240)) begin
        md = 1;
        m_door = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("key_find", int'(o_key_find), m_keys);
    chk("key_pulse", int'(o_key_pulse), int'(mp));
    chk("door_open", int'(o_door_open), int'(md));
  endtask

  task automatic press();
    btn_pick = 1'b1;
    repeat (3) step();
    btn_pick = 1'b0;
    repeat (3) step();
  endtask

  task automatic place(input int x, input int y);
    player_x = 9'(x);
    player_y = 9'(y);
  endtask

  initial begin
    int doors;
    rst = 1'b1; state = 4'd0; btn_pick = 1'b0;
    place(0, 0);
    repeat (2) step();
    rst = 1'b0;
    state = 4'd2;
    repeat (4) step();
    chk("reset_idle_kf", int'(o_key_find), 0);

    // First pick and its latency.
    place(70, 40);
    btn_pick = 1'b1;
    repeat (2) step();
    chk("lat2_no_pulse", int'(o_key_pulse), 0);
    step();
    chk("lat3_pulse", int'(o_key_pulse), 1);
    chk("lat3_kf", int'(o_key_find), 1);
    btn_pick = 1'b0;
    step();
    chk("pulse_one_cycle", int'(o_key_pulse), 0);
    press();
    chk("cooldown_ignore", int'(o_key_find), 1);
    repeat (10) step();

    place(100, 100); press();
    chk("miss_kf", int'(o_key_find), 1);
    place(240, 40); press();
    chk("k1_kf", int'(o_key_find), 2);
    repeat (10) step();
    place(240, 210); press();
    chk("k2_kf", int'(o_key_find), 3);

    place(155, 210);
    doors = 0;
    btn_pick = 1'b1;
    repeat (3) begin step(); doors += int'(o_door_open); end
    btn_pick = 1'b0;
    repeat (3) begin step(); doors += int'(o_door_open); end
    chk("door_once", doors, 1);
    press();
    state = 4'd3;
    repeat (3) step();
    chk("success_hold", int'(o_key_find), 3);
    state = 4'd0;
    step();
    chk("title_clear", int'(o_key_find), 0);

    // Hitbox boundaries around K0 and the far corner.
    state = 4'd2;
    step();
    place(49, 20); press();
    chk("edge_x_miss", int'(o_key_find), 0);
    place(50, 19); press();
    chk("edge_y_miss", int'(o_key_find), 0);
    place(50, 20); press();
    chk("edge_hit", int'(o_key_find), 1);
    repeat (10) step();
    place(318, 238); press();
    chk("far_corner", int'(o_key_find), 1);
    place(255, 40); press();
    chk("k1_right_miss", int'(o_key_find), 1);

    // Abort during cooldown with a same-cycle pick.
    place(254, 40); press();
    chk("k1_right_hit", int'(o_key_find), 2);
    btn_pick = 1'b1;
    repeat (2) step();
    state = 4'd8;
    step();
    chk("fail_abort_kf", int'(o_key_find), 0);
    chk("fail_abort_pulse", int'(o_key_pulse), 0);
    btn_pick = 1'b0;
    state = 4'd2;
    repeat (3) step();

    // Drop to TITLE in the cycle a valid pick lands.
    place(70, 40);
    btn_pick = 1'b1;
    repeat (2) step();
    state = 4'd0;
    step();
    chk("title_pick_pulse", int'(o_key_pulse), 0);
    chk("title_pick_kf", int'(o_key_find), 0);
    btn_pick = 1'b0;
    state = 4'd2;
    repeat (3) step();

    // Reset in the middle of cooldown.
    press();
    chk("pre_rst_kf", int'(o_key_find), 1);
    rst = 1'b1;
    step();
    chk("rst_cool_kf", int'(o_key_find), 0);
    rst = 1'b0;
    repeat (2) step();

    // Randomized run.
    for (int c = 0; c < 4000; c++) begin
      int r, sel, x, y;
      r = $urandom_range(0, 999);
      rst = (r < 2);
      if (r >= 2 && r < 12) state = 4'd3;
      else if (r >= 12 && r < 14) state = 4'd0;
      else if (r >= 14 && r < 16) state = 4'd8;
      else if (r >= 16 && r < 70) state = 4'd2;
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 9);
        if (sel < 5 && m_keys < 3) begin
          x = kx0[m_keys] - 18 + $urandom_range(0, 40);
          y = ky0[m_keys] - 18 + $urandom_range(0, 40);
        end else if (sel < 7) begin
          x = 134 + $urandom_range(0, 40);
          y = 184 + $urandom_range(0, 55);
        end else begin
          x = $urandom_range(0, 319);
          y = $urandom_range(0, 239);
        end
        place(x, y);
      end
      if ($urandom_range(0, 3) == 0) btn_pick = ~btn_pick;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
